// File: rtl/imm_narrow_if.sv
// Handshake bus for the immediate narrower: input word channel, result channel,
// and the sticky overflow status. The producer/consumer side uses master, the block uses slave.
interface imm_narrow_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             width_sel;
    logic             sext;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_field;
    logic             out_fit;
    logic             err;
    logic             clr_err;
    logic [CNT_W-1:0] ovf_cnt;

    modport master (
        output in_valid, in_data, width_sel, sext, out_ready, clr_err,
        input  in_ready, out_valid, out_field, out_fit, err, ovf_cnt
    );

    modport slave (
        input  in_valid, in_data, width_sel, sext, out_ready, clr_err,
        output in_ready, out_valid, out_field, out_fit, err, ovf_cnt
    );
endinterface

// File: rtl/imm_narrow.sv
// Two-stage immediate narrower: truncates a 16-bit value to a 5- or 8-bit field,
// flags whether it fits, and tracks non-fitting deliveries with a sticky flag and saturating counter.
module imm_narrow #(
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    imm_narrow_if.slave  bus
);
    logic             r_vld_p1;
    logic [15:0]      r_data_p1;
    logic             r_wsel_p1;
    logic             r_sext_p1;
    logic             r_vld_p2;
    logic [7:0]       r_field_p2;
    logic             r_fit_p2;
    logic             r_err;
    logic [CNT_W-1:0] r_ovf_cnt;

    logic w_out_valid;
    logic w_out_xfer;
    logic w_load_p2;
    logic w_in_ready;
    logic w_in_xfer;

    function automatic logic fit_calc(input logic [15:0] d, input logic wsel, input logic sx);
        logic signed [15:0] v;
        v = signed'(d);
        if (wsel) begin
            fit_calc = sx ? (v >= -16'sd128 && v <= 16'sd127) : (d[15:8] == 8'h00);
        end else begin
            fit_calc = sx ? (v >= -16'sd16 && v <= 16'sd15) : (d[15:5] == 11'h000);
        end
    endfunction

    function automatic logic [7:0] narrow_field(input logic [15:0] d, input logic wsel);
        narrow_field = wsel ? d[7:0] : {3'b000, d[4:0]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        sat_inc = (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    // Handshake and output gating
    assign w_out_valid = r_vld_p2 && !rst;
    assign w_out_xfer  = w_out_valid && bus.out_ready;
    assign w_load_p2   = r_vld_p1 && (!r_vld_p2 || w_out_xfer);
    assign w_in_ready  = (!r_vld_p1 || w_load_p2) && !rst;
    assign w_in_xfer   = bus.in_valid && w_in_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_field = w_out_valid ? r_field_p2 : 8'h00;
    assign bus.out_fit   = w_out_valid ? r_fit_p2 : 1'b0;
    assign bus.err       = r_err && !rst;
    assign bus.ovf_cnt   = rst ? '0 : r_ovf_cnt;

    // Stage 1: registered input word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else if (w_in_xfer) begin
            r_vld_p1 <= 1'b1;
        end else if (w_load_p2) begin
            r_vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_xfer) begin
            r_data_p1 <= bus.in_data;
            r_wsel_p1 <= bus.width_sel;
            r_sext_p1 <= bus.sext;
        end
    end

    // Stage 2: registered narrowed result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2 <= 1'b0;
        end else if (w_load_p2) begin
            r_vld_p2 <= 1'b1;
        end else if (w_out_xfer) begin
            r_vld_p2 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_load_p2) begin
            r_field_p2 <= narrow_field(r_data_p1, r_wsel_p1);
            r_fit_p2   <= fit_calc(r_data_p1, r_wsel_p1, r_sext_p1);
        end
    end

    // Status: set from a delivered non-fitting result takes priority over clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err     <= 1'b0;
            r_ovf_cnt <= '0;
        end else begin
            if (w_out_xfer && !r_fit_p2) begin
                r_err     <= 1'b1;
                r_ovf_cnt <= sat_inc(r_ovf_cnt);
            end else if (bus.clr_err) begin
                r_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_imm_narrow.sv
// Directed bench for imm_narrow: fit/truncation patterns, backpressure stream,
// sticky error and saturating counter behaviour, and reset with a full pipeline.
module tb_imm_narrow;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imm_narrow_if #(.CNT_W(2)) bus();
    imm_narrow #(.CNT_W(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_assert = 0;
    int n_fail   = 0;
    int acc;
    int got;
    logic [15:0] sw [4];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic w, input logic s,
                        input logic [7:0] ef, input logic efit, input logic clr, input string tag);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.width_sel = w;
        bus.sext      = s;
        step();
        bus.in_valid = 1'b0;
        chk({tag, "_lat1_valid"}, 16'(bus.out_valid), 16'd0);
        step();
        chk({tag, "_valid"}, 16'(bus.out_valid), 16'd1);
        chk({tag, "_field"}, 16'(bus.out_field), 16'(ef));
        chk({tag, "_fit"}, 16'(bus.out_fit), 16'(efit));
        bus.clr_err = clr;
        step();
        bus.clr_err = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.width_sel = 1'b0;
        bus.sext      = 1'b0;
        bus.out_ready = 1'b0;
        bus.clr_err   = 1'b0;
        step();
        step();
        chk("rst_in_ready", 16'(bus.in_ready), 16'd0);
        chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
        chk("rst_out_field", 16'(bus.out_field), 16'd0);
        chk("rst_out_fit", 16'(bus.out_fit), 16'd0);
        chk("rst_err", 16'(bus.err), 16'd0);
        chk("rst_ovf", 16'(bus.ovf_cnt), 16'd0);

        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 16'(bus.in_ready), 16'd1);
        bus.out_ready = 1'b1;

        send(16'hFFF0, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, "neg16_s5");
        chk("neg16_err", 16'(bus.err), 16'd0);
        chk("neg16_ovf", 16'(bus.ovf_cnt), 16'd0);

        send(16'h0080, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, "x80_s8");
        chk("x80_s8_err", 16'(bus.err), 16'd1);
        chk("x80_s8_ovf", 16'(bus.ovf_cnt), 16'd1);

        send(16'h0080, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, "x80_z8");
        chk("x80_z8_ovf", 16'(bus.ovf_cnt), 16'd1);

        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        chk("clr_alone_err", 16'(bus.err), 16'd0);
        chk("clr_alone_ovf", 16'(bus.ovf_cnt), 16'd1);

        send(16'h0010, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, "x10_z5");
        send(16'h000F, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, "x0F_s5");
        send(16'hFF80, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, "neg128_s8");
        send(16'h0100, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "x100_z8_clr");
        chk("clr_same_err", 16'(bus.err), 16'd1);
        chk("clr_same_ovf", 16'(bus.ovf_cnt), 16'd2);

        // Backpressure stream: consumer stalls for the first three cycles
        sw[0] = 16'h0011; sw[1] = 16'h0022; sw[2] = 16'h0033; sw[3] = 16'h0044;
        acc = 0;
        got = 0;
        bus.width_sel = 1'b1;
        bus.sext      = 1'b0;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            bus.out_ready = (cyc >= 3);
            bus.in_valid  = (acc < 4);
            bus.in_data   = (acc < 4) ? sw[acc] : 16'h0000;
            #1;
            if (cyc == 2) begin
                chk("stream_accepted_before_stall", 16'(acc), 16'd2);
                chk("stream_stall_in_ready", 16'(bus.in_ready), 16'd0);
                chk("stream_stall_field", 16'(bus.out_field), 16'h0011);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("stream_word", 16'(bus.out_field), 16'(sw[got][7:0]));
                chk("stream_fit", 16'(bus.out_fit), 16'd1);
                got++;
            end
            if (bus.in_valid && bus.in_ready) acc++;
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("stream_count", 16'(got), 16'd4);
        chk("stream_ovf", 16'(bus.ovf_cnt), 16'd2);

        for (int i = 0; i < 5; i++) begin
            send(16'h1234, 1'b1, 1'b0, 8'h34, 1'b0, 1'b0, "sat");
            chk("sat_ovf", 16'(bus.ovf_cnt), 16'd3);
        end
        chk("sat_err", 16'(bus.err), 16'd1);

        // Fill both stages, then reset with the consumer ready
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h1234;
        step();
        step();
        bus.in_valid = 1'b0;
        chk("full_out_valid", 16'(bus.out_valid), 16'd1);
        chk("full_in_ready", 16'(bus.in_ready), 16'd0);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("midrst_out_valid", 16'(bus.out_valid), 16'd0);
        chk("midrst_in_ready", 16'(bus.in_ready), 16'd0);
        step();
        chk("midrst2_out_valid", 16'(bus.out_valid), 16'd0);
        chk("midrst2_field", 16'(bus.out_field), 16'd0);
        chk("midrst2_fit", 16'(bus.out_fit), 16'd0);
        chk("midrst2_err", 16'(bus.err), 16'd0);
        chk("midrst2_ovf", 16'(bus.ovf_cnt), 16'd0);
        rst = 1'b0;
        #1;
        chk("after_rst_in_ready", 16'(bus.in_ready), 16'd1);
        chk("after_rst_out_valid", 16'(bus.out_valid), 16'd0);
        step();
        step();
        chk("drained_out_valid", 16'(bus.out_valid), 16'd0);
        chk("drained_err", 16'(bus.err), 16'd0);
        chk("drained_ovf", 16'(bus.ovf_cnt), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
